// File: rtl/alu_md_unit.sv
// alu_md_unit: WIDTH-bit ALU plus iterative MULTU/DIVU writing HI/LO.
// The divider is built only when ALU_MD_DIVU_EN is defined; otherwise DIVU behaves as an undefined code.
module alu_md_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       signal,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam logic [5:0] F_SLL   = 6'd0;
   localparam logic [5:0] F_SRL   = 6'd2;
   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_SLT   = 6'd42;
   localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state;
   logic [SHAMT_W-1:0] cnt;
   logic [WIDTH-1:0]   op;
   logic [WIDTH-1:0]   alu;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     mul_sum;

   assign in_ready = state == IDLE;
   assign busy     = state != IDLE;

   // acc = {partial product, remaining multiplier bits}; shift right one bit per step
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & op};
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef ALU_MD_DIVU_EN
   localparam logic [5:0] F_DIVU = 6'd27;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH-1:0]   rem_sub;
   logic               ge;
   logic [2*WIDTH-1:0] div_next;
   // acc = {remainder, dividend bits shifting out / quotient bits shifting in}
   assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign ge       = rem_sh >= {1'b0, op};
   assign rem_sub  = rem_sh[WIDTH-1:0] - op;
   assign div_next = {ge ? rem_sub : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], ge};
`endif

   always_comb begin
      alu = '0;
      case (signal)
         F_AND:   alu = a & b;
         F_OR:    alu = a | b;
         F_ADD:   alu = a + b;
         F_SUB:   alu = a - b;
         F_SLT:   alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         F_SLL:   alu = a << b[SHAMT_W-1:0];
         F_SRL:   alu = a >> b[SHAMT_W-1:0];
         F_MFHI:  alu = hi;
         F_MFLO:  alu = lo;
         default: alu = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         op        <= '0;
         acc       <= '0;
         result    <= '0;
         out_valid <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: if (in_valid) begin
               cnt <= '0;
               if (signal == F_MULTU) begin
                  op    <= a;
                  acc   <= {{WIDTH{1'b0}}, b};
                  state <= MUL;
               end
`ifdef ALU_MD_DIVU_EN
               else if (signal == F_DIVU) begin
                  op    <= b;
                  acc   <= {{WIDTH{1'b0}}, a};
                  state <= DIV;
               end
`endif
               else begin
                  result    <= alu;
                  out_valid <= 1'b1;
               end
            end
            MUL: begin
               acc <= mul_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= DONE;
            end
`ifdef ALU_MD_DIVU_EN
            DIV: if (op == '0) begin
               acc   <= {acc[WIDTH-1:0], {WIDTH{1'b1}}};
               state <= DONE;
            end else begin
               acc <= div_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= DONE;
            end
`endif
            DONE: begin
               hi        <= acc[2*WIDTH-1:WIDTH];
               lo        <= acc[WIDTH-1:0];
               result    <= acc[WIDTH-1:0];
               out_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_md_unit.sv
// tb_alu_md_unit: scoreboard bench for alu_md_unit at WIDTH=32 and WIDTH=8.
// DIVU expectations follow ALU_MD_DIVU_EN.
module tb_alu_md_unit;
   localparam logic [5:0] F_SLL   = 6'd0;
   localparam logic [5:0] F_SRL   = 6'd2;
   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_DIVU  = 6'd27;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_SLT   = 6'd42;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        v32, rdy32, ov32, busy32;
   logic [5:0]  sig32;
   logic [31:0] a32, b32, r32, hi32, lo32;
   logic        v8, rdy8, ov8, busy8;
   logic [5:0]  sig8;
   logic [7:0]  a8, b8, r8, hi8, lo8;

   alu_md_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .in_valid(v32), .in_ready(rdy32), .signal(sig32),
      .a(a32), .b(b32), .result(r32), .out_valid(ov32), .busy(busy32), .hi(hi32), .lo(lo32)
   );

   alu_md_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .signal(sig8),
      .a(a8), .b(b8), .result(r8), .out_valid(ov8), .busy(busy8), .hi(hi8), .lo(lo8)
   );

   int          vectors = 0;
   int          errors = 0;
   logic [31:0] q32[$];
   logic [7:0]  q8[$];
   logic [31:0] m_hi32 = '0, m_lo32 = '0;
   logic [7:0]  m_hi8 = '0, m_lo8 = '0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one request for a single cycle and pushes the modelled result.
   task automatic issue32(input logic [5:0] s, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      logic [31:0] e;
      case (s)
         F_AND:   e = x & y;
         F_OR:    e = x | y;
         F_ADD:   e = x + y;
         F_SUB:   e = x - y;
         F_SLT:   e = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         F_SLL:   e = x << y[4:0];
         F_SRL:   e = x >> y[4:0];
         F_MFHI:  e = m_hi32;
         F_MFLO:  e = m_lo32;
         F_MULTU: begin
            p = {32'd0, x} * {32'd0, y};
            m_hi32 = p[63:32];
            m_lo32 = p[31:0];
            e = m_lo32;
         end
`ifdef ALU_MD_DIVU_EN
         F_DIVU: begin
            m_lo32 = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            m_hi32 = (y == 32'd0) ? x : x % y;
            e = m_lo32;
         end
`endif
         default: e = 32'd0;
      endcase
      q32.push_back(e);
      v32 = 1'b1;
      sig32 = s;
      a32 = x;
      b32 = y;
      step();
      v32 = 1'b0;
      sig32 = 6'($urandom);
      a32 = $urandom;
      b32 = $urandom;
   endtask

   task automatic collect32(input int bound, output int lat, output int nb);
      logic [31:0] e;
      lat = 1;
      nb = 0;
      while (!ov32 && lat < bound) begin
         if (busy32 && !rdy32) nb++;
         step();
         lat++;
      end
      vectors++;
      if (!ov32) begin
         errors++;
         $display("FAIL w32_timeout: out_valid=%b after %0d cycles, want 1", ov32, bound);
      end else if (q32.size() == 0) begin
         errors++;
         $display("FAIL w32_unexpected: out_valid with result %h, want no output", r32);
      end else begin
         e = q32.pop_front();
         if (r32 !== e) begin
            errors++;
            $display("FAIL w32_result: got %h want %h", r32, e);
         end
      end
   endtask

   task automatic issue8(input logic [5:0] s, input logic [7:0] x, input logic [7:0] y);
      logic [15:0] p;
      logic [7:0]  e;
      case (s)
         F_ADD:   e = x + y;
         F_MFHI:  e = m_hi8;
         F_MULTU: begin
            p = {8'd0, x} * {8'd0, y};
            m_hi8 = p[15:8];
            m_lo8 = p[7:0];
            e = m_lo8;
         end
`ifdef ALU_MD_DIVU_EN
         F_DIVU: begin
            m_lo8 = (y == 8'd0) ? 8'hFF : x / y;
            m_hi8 = (y == 8'd0) ? x : x % y;
            e = m_lo8;
         end
`endif
         default: e = 8'd0;
      endcase
      q8.push_back(e);
      v8 = 1'b1;
      sig8 = s;
      a8 = x;
      b8 = y;
      step();
      v8 = 1'b0;
      sig8 = 6'($urandom);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
   endtask

   task automatic collect8(input int bound, output int lat, output int nb);
      logic [7:0] e;
      lat = 1;
      nb = 0;
      while (!ov8 && lat < bound) begin
         if (busy8 && !rdy8) nb++;
         step();
         lat++;
      end
      vectors++;
      if (!ov8) begin
         errors++;
         $display("FAIL w8_timeout: out_valid=%b after %0d cycles, want 1", ov8, bound);
      end else if (q8.size() == 0) begin
         errors++;
         $display("FAIL w8_unexpected: out_valid with result %h, want no output", r8);
      end else begin
         e = q8.pop_front();
         if (r8 !== e) begin
            errors++;
            $display("FAIL w8_result: got %h want %h", r8, e);
         end
      end
   endtask

   task automatic test_reset();
      int lat, nb;
      issue32(F_MULTU, 32'hFFFF_FFFF, 32'd3);
      collect32(60, lat, nb);
      vectors++;
      if (hi32 !== 32'd2) begin errors++; $display("FAIL reset_pre_hi: got %h want 2", hi32); end
      issue32(F_ADD, 32'd1, 32'd2);
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (r32 !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", r32); end
      vectors++;
      if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov32); end
      vectors++;
      if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy32); end
      vectors++;
      if (hi32 !== 32'd0 || lo32 !== 32'd0) begin errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi32, lo32); end
      vectors++;
      if (rdy32 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", rdy32); end
      vectors++;
      if ({r8, ov8, busy8, hi8, lo8} !== 26'd0) begin errors++; $display("FAIL reset_w8: got %h want 0", {r8, ov8, busy8, hi8, lo8}); end
      q32.delete();
      m_hi32 = '0;
      m_lo32 = '0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_multu();
      int lat, nb;
      issue32(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      collect32(60, lat, nb);
      vectors++;
      if (lat !== 34) begin errors++; $display("FAIL multu_latency: got %0d want 34", lat); end
      vectors++;
      if (nb !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", nb); end
      vectors++;
      if (hi32 !== 32'hFFFF_FFFE || lo32 !== 32'h0000_0001) begin
         errors++;
         $display("FAIL multu_hilo: got %h/%h want fffffffe/00000001", hi32, lo32);
      end
      step();
      vectors++;
      if (ov32 !== 1'b0) begin errors++; $display("FAIL multu_pulse: out_valid got %b want 0", ov32); end
      issue32(F_MFHI, 32'd0, 32'd0);
      collect32(4, lat, nb);
      vectors++;
      if (lat !== 1) begin errors++; $display("FAIL mfhi_latency: got %0d want 1", lat); end
      for (int i = 0; i < 3; i++) begin
         issue32(F_MULTU, $urandom, $urandom);
         collect32(60, lat, nb);
         vectors++;
         if (lat !== 34 || hi32 !== m_hi32 || lo32 !== m_lo32) begin
            errors++;
            $display("FAIL multu_rand: lat %0d hi %h lo %h want 34 %h %h", lat, hi32, lo32, m_hi32, m_lo32);
         end
      end
   endtask

   task automatic test_alu();
      logic [5:0]  s [11] = '{F_ADD, F_SLT, F_SRL, F_SUB, F_AND, F_OR, F_SLL, F_SLT, 6'd63, F_MFHI, F_MFLO};
      logic [31:0] x [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hF0F0_1234,
                              32'hF0F0_0000, 32'd3, 32'd1, 32'h1234_5678, 32'd0, 32'd0};
      logic [31:0] y [11] = '{32'd1, 32'd1, 32'h21, 32'd1, 32'h0FF0_FFFF,
                              32'h0000_0F0F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0};
      logic [5:0]  ops [7] = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_SRL};
      int lat, nb;
      for (int i = 0; i < 11; i++) begin
         issue32(s[i], x[i], y[i]);
         collect32(4, lat, nb);
         vectors++;
         if (lat !== 1) begin errors++; $display("FAIL alu_latency[%0d]: got %0d want 1", i, lat); end
      end
      for (int i = 0; i < 16; i++) begin
         issue32(ops[$urandom_range(0, 6)], $urandom, $urandom);
         collect32(4, lat, nb);
      end
   endtask

   task automatic test_divu();
      int lat, nb;
`ifdef ALU_MD_DIVU_EN
      issue32(F_DIVU, 32'd100, 32'd7);
      collect32(60, lat, nb);
      vectors++;
      if (lat !== 34 || lo32 !== 32'd14 || hi32 !== 32'd2) begin
         errors++;
         $display("FAIL divu_100_7: lat %0d lo %0d hi %0d want 34 14 2", lat, lo32, hi32);
      end
      issue32(F_DIVU, 32'd5, 32'd0);
      collect32(60, lat, nb);
      vectors++;
      if (lat !== 3 || lo32 !== 32'hFFFF_FFFF || hi32 !== 32'd5) begin
         errors++;
         $display("FAIL divu_by_zero: lat %0d lo %h hi %h want 3 ffffffff 5", lat, lo32, hi32);
      end
      issue32(F_DIVU, 32'd3, 32'd10);
      collect32(60, lat, nb);
      for (int i = 0; i < 3; i++) begin
         issue32(F_DIVU, $urandom, 32'($urandom_range(1, 32'h00FF_FFFF)));
         collect32(60, lat, nb);
         vectors++;
         if (lat !== 34 || hi32 !== m_hi32 || lo32 !== m_lo32) begin
            errors++;
            $display("FAIL divu_rand: lat %0d hi %h lo %h want 34 %h %h", lat, hi32, lo32, m_hi32, m_lo32);
         end
      end
`else
      issue32(F_DIVU, 32'd100, 32'd7);
      collect32(4, lat, nb);
      vectors++;
      if (lat !== 1 || busy32 !== 1'b0) begin errors++; $display("FAIL divu_off: lat %0d busy %b want 1 0", lat, busy32); end
      step();
      vectors++;
      if (busy32 !== 1'b0 || hi32 !== m_hi32 || lo32 !== m_lo32) begin
         errors++;
         $display("FAIL divu_off_hold: busy %b hi %h lo %h want 0 %h %h", busy32, hi32, lo32, m_hi32, m_lo32);
      end
`endif
   endtask

   task automatic test_back_to_back();
      int   accepted = 0;
      int   pulses = 0;
      logic take;
      logic [31:0] e;
      q32.push_back(32'd12);
      m_hi32 = 32'd0;
      m_lo32 = 32'd3 * 32'd4;
      v32 = 1'b1;
      sig32 = F_MULTU;
      a32 = 32'd3;
      b32 = 32'd4;
      for (int c = 0; c < 60; c++) begin
         take = v32 && rdy32;
         step();
         if (take) begin
            accepted++;
            if (sig32 == F_MULTU) begin
               sig32 = F_ADD;
               a32 = 32'd2;
               b32 = 32'd3;
               q32.push_back(32'd5);
            end else v32 = 1'b0;
         end
         if (ov32) begin
            pulses++;
            vectors++;
            e = (q32.size() != 0) ? q32.pop_front() : 32'hDEAD_BEEF;
            if (r32 !== e) begin errors++; $display("FAIL b2b_result: got %h want %h", r32, e); end
         end
      end
      v32 = 1'b0;
      vectors++;
      if (accepted !== 2 || pulses !== 2) begin
         errors++;
         $display("FAIL b2b_count: accepted %0d pulses %0d want 2 2", accepted, pulses);
      end
      vectors++;
      if (hi32 !== m_hi32 || lo32 !== m_lo32) begin errors++; $display("FAIL b2b_hilo: got %h/%h want %h/%h", hi32, lo32, m_hi32, m_lo32); end
   endtask

   task automatic test_abort();
      int lat, nb;
      issue32(F_MULTU, 32'hFFFF_FFFF, 32'd2);
      collect32(60, lat, nb);
      vectors++;
      if (hi32 !== 32'd1 || lo32 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL abort_pre: got %h/%h want 1/fffffffe", hi32, lo32); end
      issue32(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) step();
      vectors++;
      if (busy32 !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy32); end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (busy32 !== 1'b0 || rdy32 !== 1'b1) begin errors++; $display("FAIL abort_busy: busy %b ready %b want 0 1", busy32, rdy32); end
      vectors++;
      if (hi32 !== 32'd0 || lo32 !== 32'd0) begin errors++; $display("FAIL abort_hilo: got %h/%h want 0/0", hi32, lo32); end
      q32.delete();
      m_hi32 = '0;
      m_lo32 = '0;
      step();
      reset = 1'b0;
      repeat (40) step();
      vectors++;
      if (ov32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd0) begin
         errors++;
         $display("FAIL abort_stale: out_valid %b hi %h lo %h want 0 0 0", ov32, hi32, lo32);
      end
      issue32(F_ADD, 32'd2, 32'd3);
      collect32(4, lat, nb);
      vectors++;
      if (lat !== 1) begin errors++; $display("FAIL abort_add_latency: got %0d want 1", lat); end
   endtask

   task automatic test_width8();
      int lat, nb;
      issue8(F_ADD, 8'hFF, 8'h01);
      collect8(4, lat, nb);
      issue8(F_MULTU, 8'hFF, 8'hFF);
      collect8(30, lat, nb);
      vectors++;
      if (lat !== 10 || nb !== 9) begin errors++; $display("FAIL w8_multu_timing: lat %0d busy %0d want 10 9", lat, nb); end
      vectors++;
      if (hi8 !== 8'hFE || lo8 !== 8'h01) begin errors++; $display("FAIL w8_multu_hilo: got %h/%h want fe/01", hi8, lo8); end
      for (int i = 0; i < 2; i++) begin
         issue8(F_MULTU, 8'($urandom), 8'($urandom));
         collect8(30, lat, nb);
         vectors++;
         if (lat !== 10 || hi8 !== m_hi8 || lo8 !== m_lo8) begin
            errors++;
            $display("FAIL w8_multu_rand: lat %0d hi %h lo %h want 10 %h %h", lat, hi8, lo8, m_hi8, m_lo8);
         end
      end
      issue8(F_MFHI, 8'd0, 8'd0);
      collect8(4, lat, nb);
`ifdef ALU_MD_DIVU_EN
      issue8(F_DIVU, 8'd200, 8'd9);
      collect8(30, lat, nb);
      vectors++;
      if (lat !== 10 || lo8 !== 8'd22 || hi8 !== 8'd2) begin errors++; $display("FAIL w8_divu: lat %0d lo %0d hi %0d want 10 22 2", lat, lo8, hi8); end
      issue8(F_DIVU, 8'd7, 8'd0);
      collect8(30, lat, nb);
      vectors++;
      if (lat !== 3 || lo8 !== 8'hFF || hi8 !== 8'd7) begin errors++; $display("FAIL w8_divu_zero: lat %0d lo %h hi %h want 3 ff 7", lat, lo8, hi8); end
`else
      issue8(F_DIVU, 8'd200, 8'd9);
      collect8(4, lat, nb);
      vectors++;
      if (lat !== 1) begin errors++; $display("FAIL w8_divu_off_latency: got %0d want 1", lat); end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (busy8 !== 1'b0 || hi8 !== m_hi8 || lo8 !== m_lo8) begin
            errors++;
            $display("FAIL w8_divu_off_hold: busy %b hi %h lo %h want 0 %h %h", busy8, hi8, lo8, m_hi8, m_lo8);
         end
         step();
      end
`endif
   endtask

   initial begin
      reset = 1'b1;
      v32 = 1'b0;
      sig32 = '0;
      a32 = '0;
      b32 = '0;
      v8 = 1'b0;
      sig8 = '0;
      a8 = '0;
      b8 = '0;
      repeat (2) step();
      reset = 1'b0;
      step();
      test_reset();
      test_multu();
      test_alu();
      test_divu();
      test_back_to_back();
      test_abort();
      test_width8();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
      $fatal(1);
   end
endmodule
